// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the dual-bank screen RAM (banks 5/7) between the video
// fetch engine and the CPU. Video owns the RAM whenever its contend window is
// open; a CPU request arriving in that window is stalled until the window
// closes and is then given a single RAM slot of ISSUE_CE ce periods.
`timescale 1ns/1ps

module vram_arbiter #(
  parameter int unsigned ISSUE_CE = 1,   // ce periods a CPU access holds the RAM (1..3)
  parameter int unsigned WAIT_SAT = 255  // saturation value of the wait-length counter
) (
  input  logic        clock,
  input  logic        reset,     // asynchronous, active low
  input  logic        ce,
  input  logic        contend,
  input  logic        vbank,
  input  logic [12:0] vaddr,
  output logic [7:0]  vdata,
  input  logic        cpuReq,
  input  logic        cpuWr,
  input  logic [14:0] cpuAddr,
  input  logic [7:0]  cpuDout,
  output logic [7:0]  cpuDin,
  output logic        cpuAck,
  output logic        cpuWait,
  output logic [7:0]  lastWait,
  output logic [14:0] ramA,
  output logic [7:0]  ramD,
  input  logic [7:0]  ramQ,
  output logic        ramWe
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Reload value of the issue down-counter and the wait counter ceiling.
  localparam logic [1:0] ISSUE_LAST = 2'(ISSUE_CE - 1);
  localparam logic [7:0] WAIT_MAX   = 8'(WAIT_SAT);

  state_e     state_q,     state_d;
  logic [1:0] issue_cnt_q, issue_cnt_d;
  logic [7:0] wait_cnt_q,  wait_cnt_d;
  logic [7:0] cpu_din_q,   cpu_din_d;
  logic [7:0] last_wait_q, last_wait_d;
  logic       ack_q,       ack_d;
  logic       stall_q,     stall_d;
  logic       in_issue;

  // Next-state and counter logic; everything advances only on ce.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_din_d   = cpu_din_q;
    last_wait_d = last_wait_q;

    if (ce) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cpuReq) begin
            if (contend) begin
              // Video owns this ce period: the first waited period counts.
              state_d    = ST_WAIT;
              wait_cnt_d = 8'd1;
            end else begin
              state_d     = ST_ISSUE;
              issue_cnt_d = ISSUE_LAST;
              wait_cnt_d  = 8'd0;
            end
          end
        end

        ST_WAIT: begin
          if (!cpuReq) begin
            // CPU withdrew: no RAM access, last completed wait length is kept.
            state_d = ST_IDLE;
          end else if (contend) begin
            if (wait_cnt_q < WAIT_MAX) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end else begin
            state_d     = ST_ISSUE;
            issue_cnt_d = ISSUE_LAST;
          end
        end

        ST_ISSUE: begin
          // Contend rising here does not abort: the video never samples in the
          // first 4 ce of its fetch cycle, so a short slot always fits.
          if (issue_cnt_q == 2'd0) begin
            state_d     = ST_DONE;
            last_wait_d = wait_cnt_q;
            if (!cpuWr) begin
              cpu_din_d = ramQ;
            end
          end else begin
            issue_cnt_d = issue_cnt_q - 2'd1;
          end
        end

        ST_DONE: begin
          // A held request is never re-serviced; wait for it to drop.
          if (!cpuReq) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Handshake outputs are registered alongside the state they decode.
    ack_d   = (state_d == ST_DONE);
    stall_d = (state_d == ST_WAIT) || (state_d == ST_ISSUE);
  end

  // State, counter and registered-output flops with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= 2'd0;
      wait_cnt_q  <= 8'd0;
      cpu_din_q   <= 8'd0;
      last_wait_q <= 8'd0;
      ack_q       <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_din_q   <= cpu_din_d;
      last_wait_q <= last_wait_d;
      ack_q       <= ack_d;
      stall_q     <= stall_d;
    end
  end

  // RAM port mux: the CPU drives the RAM only while in ISSUE, video otherwise.
  // The write strobe decodes straight from state so reset drops it at once.
  always_comb begin
    in_issue = (state_q == ST_ISSUE);
    if (in_issue) begin
      ramA  = cpuAddr;
      ramD  = cpuDout;
      ramWe = cpuWr;
    end else begin
      ramA  = {vbank, 1'b0, vaddr};
      ramD  = 8'd0;
      ramWe = 1'b0;
    end
  end

  // Video sees RAM data directly; it only samples during contend, when the
  // address is always its own.
  assign vdata    = ramQ;
  assign cpuDin   = cpu_din_q;
  assign lastWait = last_wait_q;
  assign cpuAck   = ack_q;
  assign cpuWait  = stall_q;

endmodule
